div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, operand and result width in bits (even, >=8).
REQ-002 The module SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The module SHALL have port in_valid  input  1  request valid.
REQ-005 The module SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The module SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 The module SHALL have port dividend  input  XLEN  numerator.
REQ-008 The module SHALL have port divisor  input  XLEN  denominator.
REQ-009 The module SHALL have port out_valid  output  1  result valid.
REQ-010 The module SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The module SHALL have port result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 The block SHALL accept a request when in_valid&in_ready, latching op, operand magnitudes, and result signs (quotient sign = sign(dividend)^sign(divisor), remainder sign = sign(dividend), signed ops only).
REQ-014 The block SHALL, in CALC, produce one quotient bit per cycle by restoring division: shift partial remainder left with next dividend bit, subtract divisor magnitude (XLEN+1-bit), keep the difference and set the quotient bit iff no borrow.
REQ-015 The block SHALL run CALC for exactly XLEN cycles using a counter, then enter DONE with sign-corrected result; normal latency from accept to out_valid = XLEN+1 cycles.
REQ-016 The block SHALL, on divisor==0, skip CALC and enter DONE next cycle with quotient = all-ones, remainder = dividend (unmodified).
REQ-017 The block SHALL, on signed overflow (DIV/REM, dividend = -2^(XLEN-1), divisor = -1), skip CALC and enter DONE next cycle with quotient = -2^(XLEN-1), remainder = 0.
REQ-018 The block SHALL hold result stable and out_valid high in DONE until out_valid&out_ready, then return to IDLE the following cycle.
REQ-019 The block SHALL NOT accept a new request in the cycle it leaves DONE (no back-to-back overlap); in_ready rises one cycle after the output handshake.
REQ-020 The block SHALL ignore in_valid and input changes while in CALC or DONE.
REQ-021 The block SHALL compute unsigned ops on raw bits with no sign correction.

Reset
REQ-022 The block SHALL, on rst, enter IDLE, clear counter, partial remainder and quotient registers; outputs after reset: in_ready=1, out_valid=0, result=0.
REQ-023 The block SHALL abort any in-flight operation on rst asserted in CALC or DONE, discarding it with no out_valid pulse.

Structure
REQ-024 Op encodings (DIV/DIVU/REM/REMU), FSM state encoding and default XLEN SHALL live in the shared package.
REQ-025 The trial subtraction SHALL be a sub-module cla_sub, an (XLEN+1)-bit carry-lookahead subtractor (A + ~B + 1) returning difference and borrow.

Verification
REQ-026 DIVU 100/7 -> result 14 after XLEN+1 cycles; REMU 100/7 -> 2.
REQ-027 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-028 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; both out_valid 1 cycle after accept.
REQ-029 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-030 out_ready held 0 for 10 cycles in DONE -> result/out_valid stable; in_ready stays 0 until one cycle after handshake.
REQ-031 rst asserted mid-CALC (cycle 10) -> next cycle in_ready=1, out_valid=0; subsequent DIVU 9/3 -> 3.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and defaults for the iterative integer divider.
package div_iter_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/cla_sub.sv
// W-bit carry-lookahead subtractor computing a + ~b + 1 with a parallel-prefix carry tree.
module cla_sub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] g, p, gg, pp, gn, pn;
  logic [W:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  always_comb begin
    gg = g;
    pp = p;
    gn = g;
    pn = p;
    for (int d = 1; d < int'(W); d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < int'(W); i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    // Carry-in is 1, so each prefix carry is G | P.
    c[0] = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      c[i+1] = gg[i] | pp[i];
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned DIV/REM.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  state_e          state_q;
  op_e             op_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, divs_q, result_q;
  logic            neg_q_q, neg_r_q, in_ready_q, out_valid_q;

  // Accept-time decode
  logic            is_signed, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, int_min;

  assign int_min   = {1'b1, {(XLEN-1){1'b0}}};
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed & (dividend == int_min) & (divisor == '1);

  // One restoring step
  logic [XLEN:0]   rem_shift, sub_diff;
  logic            sub_borrow, sub_unused;
  logic [XLEN-1:0] rem_next, quo_next, q_fin, r_fin;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};

  cla_sub #(
    .W(XLEN + 1)
  ) u_sub (
    .a     (rem_shift),
    .b     ({1'b0, divs_q}),
    .diff  (sub_diff),
    .borrow(sub_borrow)
  );

  // The top difference bit is always zero when kept, since remainder < divisor.
  assign sub_unused = sub_diff[XLEN];

  assign rem_next = sub_borrow ? rem_shift[XLEN-1:0] : sub_diff[XLEN-1:0];
  assign quo_next = {quo_q[XLEN-2:0], ~sub_borrow};
  assign q_fin    = neg_q_q ? -quo_next : quo_next;
  assign r_fin    = neg_r_q ? -rem_next : rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpDiv;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divs_q      <= '0;
      result_q    <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q       <= op_e'(op);
            in_ready_q <= 1'b0;
            if (div_zero) begin
              result_q    <= op[1] ? dividend : '1;
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else if (overflow) begin
              result_q    <= op[1] ? '0 : int_min;
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= a_mag;
              divs_q  <= b_mag;
              neg_q_q <= a_neg ^ b_neg;
              neg_r_q <= a_neg;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            result_q    <= op_q[1] ? r_fin : q_fin;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
